// File: rtl/aes_key_expand_if.sv
// aes_key_expand_if -- bus bundle for the AES-128 key expander.
//   master : drives start/key_in/rd_idx, observes status, stream and read data
//   slave  : the expander itself
// Signals:
//   start     load key_in and begin an expansion
//   key_in    128-bit cipher key, [127:96] is word w0
//   busy      expansion in progress
//   done      all 11 round keys stored
//   rk_valid  rk_out/rk_round carry a fresh round key this cycle
//   rk_round  index 0..10 of the key on rk_out
//   rk_out    round key stream
//   rd_idx    random-read index into the stored round keys
//   rd_key    stored key at rd_idx, one cycle later (0 for 11..15)
interface aes_key_expand_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] rk_out;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    modport master (
        output start, key_in, rd_idx,
        input  busy, done, rk_valid, rk_round, rk_out, rd_key
    );

    modport slave (
        input  start, key_in, rd_idx,
        output busy, done, rk_valid, rk_round, rk_out, rd_key
    );
endinterface

// File: rtl/aes_key_expand.sv
// aes_key_expand -- iterative AES-128 key schedule, one round key per cycle.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous, active-low reset (clears state, stream, store, read)
//   bus     aes_key_expand_if.slave (start/key_in in, busy/done/rk_* out,
//           rd_idx in, rd_key out)
// Accepting start emits round 0 on the same edge; rounds 1..10 follow on the
// next ten edges, and the block settles in DONE one edge after round 10.
module aes_key_expand (
    input  logic               clk,
    input  logic               resetn,
    aes_key_expand_if.slave    bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // Counter value that marks "round 10 already emitted".
    localparam logic [3:0] RND_END = 4'd11;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [1:0]   state_q,    state_d;
    logic [3:0]   rnd_q,      rnd_d;
    logic [127:0] key_q,      key_d;
    logic [127:0] rk_out_q,   rk_out_d;
    logic [3:0]   rk_round_q, rk_round_d;
    logic         rk_valid_q, rk_valid_d;
    logic [127:0] rd_key_q;
    logic [127:0] store_q [0:10];

    logic         st_we;
    logic [3:0]   st_idx;
    logic [127:0] st_data;

    // Next round key from the working key and the current round counter.
    logic [31:0]  w0, w1, w2, w3, rot_w, t_w;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] key_next;

    assign {w0, w1, w2, w3} = key_q;
    assign rot_w = {w3[23:0], w3[31:24]};
    assign t_w   = {aes_sbox(rot_w[31:24]), aes_sbox(rot_w[23:16]),
                    aes_sbox(rot_w[15:8]),  aes_sbox(rot_w[7:0])}
                   ^ {rcon(rnd_q), 24'h0};
    assign n0 = w0 ^ t_w;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign key_next = {n0, n1, n2, n3};

    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        key_d      = key_q;
        rk_out_d   = rk_out_q;
        rk_round_d = rk_round_q;
        rk_valid_d = 1'b0;
        st_we      = 1'b0;
        st_idx     = 4'd0;
        st_data    = key_next;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d    = S_EXPAND;
                    rnd_d      = 4'd1;
                    key_d      = bus.key_in;
                    rk_out_d   = bus.key_in;
                    rk_round_d = 4'd0;
                    rk_valid_d = 1'b1;
                    st_we      = 1'b1;
                    st_idx     = 4'd0;
                    st_data    = bus.key_in;
                end
            end
            S_EXPAND: begin
                // start is deliberately not looked at here.
                if (rnd_q == RND_END) begin
                    state_d = S_DONE;
                    rnd_d   = 4'd0;
                end else begin
                    key_d      = key_next;
                    rk_out_d   = key_next;
                    rk_round_d = rnd_q;
                    rk_valid_d = 1'b1;
                    st_we      = 1'b1;
                    st_idx     = rnd_q;
                    rnd_d      = rnd_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            rnd_q      <= 4'd0;
            key_q      <= '0;
            rk_out_q   <= '0;
            rk_round_q <= 4'd0;
            rk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rnd_q      <= rnd_d;
            key_q      <= key_d;
            rk_out_q   <= rk_out_d;
            rk_round_q <= rk_round_d;
            rk_valid_q <= rk_valid_d;
        end
    end

    // Key store and read port; a same-edge read sees the pre-write entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 11; i++) store_q[i] <= '0;
            rd_key_q <= '0;
        end else begin
            if (st_we) store_q[st_idx] <= st_data;
            rd_key_q <= (bus.rd_idx > 4'd10) ? '0 : store_q[bus.rd_idx];
        end
    end

    assign bus.busy     = (state_q == S_EXPAND);
    assign bus.done     = (state_q == S_DONE);
    assign bus.rk_valid = rk_valid_q;
    assign bus.rk_round = rk_round_q;
    assign bus.rk_out   = rk_out_q;
    assign bus.rd_key   = rd_key_q;
endmodule

// File: tb/tb_aes_key_expand.sv
module tb_aes_key_expand;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    aes_key_expand_if bus();

    aes_key_expand dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [127:0] fips [0:10];
    logic [127:0] zr1, zr10;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zr1      = 128'h62636363626363636263636362636363;
        zr10     = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        bus.start  = 1'b0;
        bus.key_in = '0;
        bus.rd_idx = 4'd0;

        // Reset state
        step();
        step();
        chk("rst_busy",     128'(bus.busy),     128'd0);
        chk("rst_done",     128'(bus.done),     128'd0);
        chk("rst_rk_valid", 128'(bus.rk_valid), 128'd0);
        chk("rst_rk_round", 128'(bus.rk_round), 128'd0);
        chk("rst_rk_out",   bus.rk_out,         128'd0);
        chk("rst_rd_key",   bus.rd_key,         128'd0);
        resetn = 1'b1;

        // FIPS-197 key, accepted on the first edge after release
        bus.start  = 1'b1;
        bus.key_in = fips[0];
        step();
        bus.start = 1'b0;
        chk("f_valid0", 128'(bus.rk_valid), 128'd1);
        chk("f_round0", 128'(bus.rk_round), 128'd0);
        chk("f_rk0",    bus.rk_out,         fips[0]);
        chk("f_busy0",  128'(bus.busy),     128'd1);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("f_valid%0d", k), 128'(bus.rk_valid), 128'd1);
            chk($sformatf("f_round%0d", k), 128'(bus.rk_round), 128'(k));
            chk($sformatf("f_rk%0d", k),    bus.rk_out,         fips[k]);
            chk($sformatf("f_done%0d", k),  128'(bus.done),     128'd0);
        end
        step();
        chk("f_done",      128'(bus.done),     128'd1);
        chk("f_busy_end",  128'(bus.busy),     128'd0);
        chk("f_valid_end", 128'(bus.rk_valid), 128'd0);
        chk("f_hold_out",  bus.rk_out,         fips[10]);
        chk("f_hold_rnd",  128'(bus.rk_round), 128'd10);

        // Readback sweep
        for (int i = 0; i < 16; i++) begin
            bus.rd_idx = 4'(i);
            step();
            chk($sformatf("rb_idx%0d", i), bus.rd_key, (i <= 10) ? fips[i] : 128'd0);
        end

        // Zero key from DONE, with an ignored start in the middle
        bus.start  = 1'b1;
        bus.key_in = '0;
        step();
        bus.start = 1'b0;
        chk("z_round0", 128'(bus.rk_round), 128'd0);
        chk("z_rk0",    bus.rk_out,         128'd0);
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) begin
                bus.start  = 1'b1;
                bus.key_in = fips[0];
            end
            step();
            bus.start = 1'b0;
            chk($sformatf("z_valid%0d", k), 128'(bus.rk_valid), 128'd1);
            chk($sformatf("z_round%0d", k), 128'(bus.rk_round), 128'(k));
            if (k == 1)  chk("z_rk1",  bus.rk_out, zr1);
            if (k == 10) chk("z_rk10", bus.rk_out, zr10);
        end
        step();
        chk("z_done", 128'(bus.done), 128'd1);

        // Back-to-back: new start in the cycle done rose
        bus.start  = 1'b1;
        bus.key_in = fips[0];
        step();
        bus.start = 1'b0;
        chk("bb_busy",   128'(bus.busy),     128'd1);
        chk("bb_round0", 128'(bus.rk_round), 128'd0);
        chk("bb_rk0",    bus.rk_out,         fips[0]);
        for (int k = 1; k <= 10; k++) begin
            if (k == 6)  bus.rd_idx = 4'd1;
            if (k == 7)  bus.rd_idx = 4'd9;
            if (k == 10) bus.rd_idx = 4'd10;
            step();
            chk($sformatf("bb_round%0d", k), 128'(bus.rk_round), 128'(k));
            chk($sformatf("bb_rk%0d", k),    bus.rk_out,         fips[k]);
            if (k == 6)  chk("bb_rd1_new",  bus.rd_key, fips[1]);
            if (k == 10) chk("bb_rd10_old", bus.rd_key, zr10);
        end
        step();
        chk("bb_rd10_new", bus.rd_key,     fips[10]);
        chk("bb_done",     128'(bus.done), 128'd1);

        // Reset mid-expansion at round 5
        bus.start  = 1'b1;
        bus.key_in = fips[0];
        bus.rd_idx = 4'd3;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        chk("ra_round5", 128'(bus.rk_round), 128'd5);
        resetn = 1'b0;
        #1;
        chk("ra_busy",     128'(bus.busy),     128'd0);
        chk("ra_done",     128'(bus.done),     128'd0);
        chk("ra_rk_valid", 128'(bus.rk_valid), 128'd0);
        chk("ra_rk_round", 128'(bus.rk_round), 128'd0);
        chk("ra_rk_out",   bus.rk_out,         128'd0);
        chk("ra_rd_key",   bus.rd_key,         128'd0);
        step();
        step();
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("ra_idle_valid%0d", c), 128'(bus.rk_valid), 128'd0);
            chk($sformatf("ra_idle_busy%0d", c),  128'(bus.busy),     128'd0);
        end
        for (int i = 0; i < 16; i++) begin
            bus.rd_idx = 4'(i);
            step();
            chk($sformatf("ra_rd%0d", i), bus.rd_key, 128'd0);
        end

        // start held high for 20 cycles from IDLE
        bus.start  = 1'b1;
        bus.key_in = fips[0];
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c <= 11) begin
                chk($sformatf("h_valid%0d", c), 128'(bus.rk_valid), 128'd1);
                chk($sformatf("h_round%0d", c), 128'(bus.rk_round), 128'(c - 1));
                chk($sformatf("h_rk%0d", c),    bus.rk_out,         fips[c - 1]);
            end else if (c == 12) begin
                chk("h_valid12", 128'(bus.rk_valid), 128'd0);
                chk("h_done12",  128'(bus.done),     128'd1);
            end else begin
                chk($sformatf("h_valid%0d", c), 128'(bus.rk_valid), 128'd1);
                chk($sformatf("h_round%0d", c), 128'(bus.rk_round), 128'(c - 13));
                chk($sformatf("h_rk%0d", c),    bus.rk_out,         fips[c - 13]);
            end
        end
        bus.start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  clock, rising-edge.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  load key_in and begin expansion; sampled only in IDLE or DONE.
- key_in  in  128  AES-128 cipher key; bits [127:96] are word w0.
- busy  out  1  high while expansion is in progress.
- done  out  1  high while all 11 round keys are stored and valid.
- rk_valid  out  1  high when rk_out/rk_round carry a new round key this cycle.
- rk_round  out  4  index 0..10 of the key on rk_out.
- rk_out  out  128  round key stream that feeds the downstream round stages' KEY input.
- rd_idx  in  4  random-read index into the stored round keys.
- rd_key  out  128  stored round key at rd_idx, one-cycle registered latency.
REQ-002 SubWord SHALL use four instances of the team's combinational aes_sbox byte function.

Function
REQ-003 The FSM SHALL have three states: IDLE, EXPAND, DONE.
- IDLE or DONE with start=1 -> EXPAND.
- EXPAND after round 10 is emitted -> DONE.
- Any other condition holds the current state.
REQ-004 On the edge that accepts start, the block SHALL load key_in into the working key and into store[0], drive rk_out=key_in, rk_round=0, rk_valid=1, and set the round counter to 1.
REQ-005 On each EXPAND edge with round counter r (1..10), the block SHALL compute the next key as follows:
- t = SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}.
- w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- Write the result to the working key, store[r] and rk_out; set rk_round=r, rk_valid=1; then r = r+1.
REQ-006 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-007 rk_valid SHALL be high for exactly 11 consecutive cycles per expansion, with rk_round 0..10 in order, and low in every other cycle.
REQ-008 busy SHALL be 1 in EXPAND and 0 otherwise.
REQ-009 done SHALL be 1 in DONE and 0 otherwise; done rises on the edge after rk_round=10 is presented.
REQ-010 Expansion latency SHALL be fixed:
- Round 0 key is visible 1 cycle after start is sampled.
- Round 10 key is visible 11 cycles after start is sampled.
- done is high 12 cycles after start is sampled.
REQ-011 start asserted during EXPAND SHALL be ignored, with no restart, no change to the stream and no error.
REQ-012 start asserted in DONE SHALL restart expansion with the new key_in; stored keys are overwritten progressively.
REQ-013 Read behaviour:
- rd_key SHALL be updated every cycle with store[rd_idx].
- rd_idx values 11..15 SHALL return 128'h0.
- A read of an index written in the same cycle SHALL return the pre-write value.
REQ-014 When rk_valid=0, rk_out and rk_round SHALL hold their last values.
REQ-015 A round key stream that starts while rd_idx is being swept SHALL NOT stall the reads; the read port is independent of the FSM.

Reset
REQ-016 While resetn=0, regardless of clk, the block SHALL force the following:
- State IDLE, round counter 0.
- busy=0, done=0, rk_valid=0, rk_round=0.
- rk_out=0, rd_key=0, working key=0.
- All 11 store entries = 0.
REQ-017 Reset asserted mid-expansion SHALL abort the expansion; after release, the block stays in IDLE until start.
REQ-018 The first start SHALL be accepted on the first rising edge after resetn deasserts.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- FIPS-197 key: key_in=2b7e151628aed2a6abf7158809cf4f3c, start pulse -> rk_round 0..10 on 11 consecutive cycles; round1=a0fafe1788542cb123a339392a6c7605; round10=d014f9a8c9ee2589e13f0cc8b6630ca6; done high the following cycle.
- Zero key: key_in=0 -> round1=62636363626363636263636362636363; round10=b4ef5bcb3e92e21123e951cf6f8f188e.
- Readback: after done, sweep rd_idx 0..15 -> rd_key equals the streamed keys one cycle later; 11..15 return 0.
- start held high for 20 cycles from IDLE -> exactly one expansion of 11 rk_valid cycles, then a restart from DONE at cycle 12 with the same stream.
- resetn pulsed low at rk_round=5 -> all outputs 0 immediately; no rk_valid after release until start; rd_key for every idx = 0.
- Back-to-back: second start with a different key in the cycle done rises -> busy=1 next cycle; second stream correct; old store entries replaced in round order.
